descrambler_sync_ctrl: RTL and testbench
========================================

// Module: descrambler_sync_ctrl
// PURPOSE
//  Frame-sync and sequencing controller for the 15-bit LFSR serial descrambler (x^15+x^14+1).
//  - Hunts for a sync word in the raw serial stream and declares lock after LOCK_HITS consecutive good syncs.
//  - Flywheels through missed syncs; drops lock after LOSS_MISSES consecutive misses.
//  - Drives the descrambler: seed reload at every frame boundary, advance/enable only on valid payload bits.
//  - Forwards payload bits with frame markers.
// PARAMETERS
//  SYNC_LEN     16        sync word length, bits (2..32)
//  SYNC_WORD    16'hF628  sync pattern; first-received bit = MSB
//  PAYLOAD_LEN  64        payload bits per frame (>=2); FRAME_LEN = SYNC_LEN+PAYLOAD_LEN
//  LOCK_HITS    2         consecutive verified syncs needed to enter LOCKED (>=1)
//  LOSS_MISSES  3         consecutive missed syncs in LOCKED that return to HUNT (>=1)
//  SEED         15'h57E5  LFSR reload value presented on descr_seed
// PORTS
//  clk           in   1         rising-edge clock
//  rst           in   1         synchronous, active-high reset
//  ctrl_en       in   1         0: force HUNT next cycle, all outputs to reset values
//  in_bit        in   1         raw serial bit
//  in_valid      in   1         in_bit qualifier; when 0, all state holds
//  out_bit       out  1         payload bit, 1-cycle latency, to descrambler scrambled_in
//  out_valid     out  1         out_bit valid (LOCKED payload only)
//  out_sof       out  1         with out_valid on payload bit 0
//  out_eof       out  1         with out_valid on payload bit PAYLOAD_LEN-1
//  descr_load    out  1         1-cycle pulse: descrambler reloads descr_seed on next edge
//  descr_enable  out  1         descrambler advance/XOR enable; equals out_valid
//  descr_seed    out  15        constant SEED
//  locked        out  1         high in LOCKED state
//  state         out  2         00 HUNT, 01 VERIFY, 10 LOCKED
//  sync_err_cnt  out  8         saturating count of missed syncs while LOCKED
// BEHAVIOUR
//  - Reset: state=HUNT; all outputs 0 except descr_seed=SEED; shift reg, pos, hit/miss counters = 0.
//  - win = {shreg[SYNC_LEN-2:0], in_bit}; hit = in_valid && win==SYNC_WORD.
//  - shreg shifts only when in_valid=1.
//  - pos counts 0..FRAME_LEN-1 on in_valid:
//      payload bits at pos 0..PAYLOAD_LEN-1; sync bits follow.
//      check point = pos FRAME_LEN-1 (last sync bit); pos wraps to 0 after it.
//  - HUNT: pos ignored.
//      hit -> VERIFY, pos<=0, hit_cnt<=1, descr_load pulse.
//      If LOCK_HITS==1, hit -> LOCKED directly.
//  - VERIFY: no payload output.
//      Check-point hit -> hit_cnt++, descr_load pulse; hit_cnt==LOCK_HITS -> LOCKED, miss_cnt<=0.
//      Check-point miss -> HUNT; no load.
//  - LOCKED:
//      Payload bits -> out_bit/out_valid/descr_enable next cycle; sof/eof at pos 0 / PAYLOAD_LEN-1.
//      Every check point -> descr_load pulse, hit or miss (flywheel keeps LFSR frame-aligned).
//      Hit -> miss_cnt<=0.
//      Miss -> miss_cnt++ and sync_err_cnt++ (saturates at 255).
//      miss_cnt==LOSS_MISSES -> HUNT, same cycle as that miss; no load pulse on this transition.
//  - Output timing: all outputs registered; latency in_bit -> out_bit = 1 cycle.
//      descr_load is high in the cycle after the last sync bit is accepted.
//      This precedes or coincides with payload bit 0 arriving, so the reload lands before the bit is descrambled.
//  - in_valid gaps: pos, counters and state hold; out_valid/descr_enable/descr_load deassert during gaps.
//  - Pulse outputs (descr_load, out_sof, out_eof) are never asserted for more than one cycle per event.
//  - ctrl_en=0 or rst mid-frame: abort immediately.
//      No partial eof; next frame needs a full re-hunt.
//      sync_err_cnt is cleared only by rst.
//  - Priority: rst > ctrl_en=0 > state logic.
// STRUCTURE
//  - descr_ctrl_defs.vh: state encodings ST_HUNT/ST_VERIFY/ST_LOCKED; default SYNC_WORD and SEED.
//  - Sub-module sync_detector: SYNC_LEN shift register + comparator, outputs hit.
//  - Top: FSM, pos counter, hit/miss counters, registered outputs.
// TESTING
//  - Default params; three error-free frames of sync F628 + 64 payload bits:
//      VERIFY after frame 1 sync; LOCKED at frame 2 check point.
//      Frame 3 payload output with sof/eof; descr_load one cycle after each sync.
//  - LOCKED; corrupt two consecutive syncs, then a good one:
//      stays LOCKED, sync_err_cnt=2, miss_cnt cleared.
//      Three consecutive misses -> HUNT on the third check point; out_valid stays 0 afterwards.
//  - Random in_valid (50%) during a locked frame:
//      64 out_valid pulses, identical bit sequence; pos unaffected by gaps.
//  - Sync pattern appears inside VERIFY payload, true sync corrupted: VERIFY -> HUNT at check point.
//      Spurious in-payload pattern is ignored while in VERIFY/LOCKED.
//  - rst asserted at payload bit 30 of a LOCKED frame:
//      all outputs 0 next cycle, state=HUNT, sync_err_cnt=0, no eof.
//      ctrl_en=0 for 1 cycle gives the same result except sync_err_cnt is kept.
//  - Closed loop with descrambler + scrambler seeded 15'h57E5:
//      recovered payload equals transmitted payload over 100 frames.

Source files
------------

// File: rtl/descrambler_sync_ctrl_pkg.sv
// Shared state encoding and default sync/seed constants for the descrambler
// frame-sync controller.
package descrambler_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  localparam logic [15:0] DEF_SYNC_WORD = 16'hF628;
  localparam logic [14:0] DEF_SEED      = 15'h57E5;

endpackage

// File: rtl/descrambler_sync_ctrl_sync_detector.sv
// Serial sync-word detector: SYNC_LEN-bit window over the raw stream, where
// the first-received bit lands in the MSB.
module descrambler_sync_ctrl_sync_detector #(
  parameter int unsigned           SYNC_LEN  = 16,
  parameter logic [SYNC_LEN-1:0]   SYNC_WORD = '0
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic bit_i,
  input  logic valid_i,
  output logic hit_o
);

  logic [SYNC_LEN-2:0] shreg_q;
  logic [SYNC_LEN-1:0] win;

  assign win   = {shreg_q, bit_i};
  assign hit_o = valid_i && (win == SYNC_WORD);

  always_ff @(posedge clk_i) begin
    if (clr_i)        shreg_q <= '0;
    else if (valid_i) shreg_q <= win[SYNC_LEN-2:0];
  end

endmodule

// File: rtl/descrambler_sync_ctrl.sv
// Frame-sync controller for the x^15+x^14+1 serial descrambler: hunt/verify/lock
// on the sync word, flywheel through misses, and sequence the descrambler.
module descrambler_sync_ctrl
  import descrambler_sync_ctrl_pkg::*;
#(
  parameter int unsigned         SYNC_LEN    = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = SYNC_LEN'(DEF_SYNC_WORD),
  parameter int unsigned         PAYLOAD_LEN = 64,
  parameter int unsigned         LOCK_HITS   = 2,
  parameter int unsigned         LOSS_MISSES = 3,
  parameter logic [14:0]         SEED        = DEF_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ctrl_en_i,
  input  logic        in_bit_i,
  input  logic        in_valid_i,
  output logic        out_bit_o,
  output logic        out_valid_o,
  output logic        out_sof_o,
  output logic        out_eof_o,
  output logic        descr_load_o,
  output logic        descr_enable_o,
  output logic [14:0] descr_seed_o,
  output logic        locked_o,
  output logic [1:0]  state_o,
  output logic [7:0]  sync_err_cnt_o
);

  localparam int unsigned FRAME_LEN = SYNC_LEN + PAYLOAD_LEN;
  localparam int unsigned PW = $clog2(FRAME_LEN);
  localparam int unsigned HW = $clog2(LOCK_HITS + 1);
  localparam int unsigned MW = $clog2(LOSS_MISSES + 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [HW-1:0] hit_cnt_q, hit_cnt_d, hits_nxt;
  logic [MW-1:0] miss_cnt_q, miss_cnt_d, miss_nxt;
  logic [7:0]    err_q, err_d;
  logic          bit_q, bit_d, vld_q, vld_d, sof_q, sof_d, eof_q, eof_d;
  logic          load_q, load_d;
  logic          hit, clr, chk_pt, pay;

  assign clr = rst_i | ~ctrl_en_i;

  descrambler_sync_ctrl_sync_detector #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_detector (
    .clk_i   (clk_i),
    .clr_i   (clr),
    .bit_i   (in_bit_i),
    .valid_i (in_valid_i),
    .hit_o   (hit)
  );

  assign chk_pt   = in_valid_i && (pos_q == PW'(FRAME_LEN - 1));
  assign pay      = in_valid_i && (pos_q < PW'(PAYLOAD_LEN));
  assign hits_nxt = hit_cnt_q + HW'(1);
  assign miss_nxt = miss_cnt_q + MW'(1);

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    err_d      = err_q;
    bit_d      = 1'b0;
    vld_d      = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    load_d     = 1'b0;

    if (in_valid_i && state_q != ST_HUNT)
      pos_d = chk_pt ? '0 : pos_q + PW'(1);

    case (state_q)
      ST_HUNT: begin
        if (hit) begin
          pos_d      = '0;
          hit_cnt_d  = HW'(1);
          miss_cnt_d = '0;
          load_d     = 1'b1;
          state_d    = (LOCK_HITS == 1) ? ST_LOCKED : ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (chk_pt) begin
          if (hit) begin
            hit_cnt_d = hits_nxt;
            load_d    = 1'b1;
            if (hits_nxt == HW'(LOCK_HITS)) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            state_d = ST_HUNT;
          end
        end
      end
      ST_LOCKED: begin
        if (pay) begin
          bit_d = in_bit_i;
          vld_d = 1'b1;
          sof_d = (pos_q == '0);
          eof_d = (pos_q == PW'(PAYLOAD_LEN - 1));
        end
        // Reload on misses too so the LFSR stays frame-aligned while flywheeling.
        if (chk_pt) begin
          if (hit) begin
            miss_cnt_d = '0;
            load_d     = 1'b1;
          end else begin
            err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            if (miss_nxt == MW'(LOSS_MISSES)) begin
              state_d    = ST_HUNT;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_nxt;
              load_d     = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    if (!ctrl_en_i) begin
      state_d    = ST_HUNT;
      pos_d      = '0;
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      bit_d      = 1'b0;
      vld_d      = 1'b0;
      sof_d      = 1'b0;
      eof_d      = 1'b0;
      load_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_HUNT;
      pos_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      err_q      <= '0;
      bit_q      <= 1'b0;
      vld_q      <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      err_q      <= err_d;
      bit_q      <= bit_d;
      vld_q      <= vld_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      load_q     <= load_d;
    end
  end

  assign out_bit_o      = bit_q;
  assign out_valid_o    = vld_q;
  assign out_sof_o      = sof_q;
  assign out_eof_o      = eof_q;
  assign descr_load_o   = load_q;
  assign descr_enable_o = vld_q;
  assign descr_seed_o   = SEED;
  assign locked_o       = (state_q == ST_LOCKED);
  assign state_o        = state_q;
  assign sync_err_cnt_o = err_q;

endmodule

// File: tb/tb_descrambler_sync_ctrl.sv
// Randomized bench for descrambler_sync_ctrl against a bit-history reference
// model, plus a closed scrambler/descrambler loop.
module tb_descrambler_sync_ctrl;

  localparam int SL = 16, PL = 64, FL = 80, LH = 2, LM = 3;
  localparam logic [15:0] SW   = 16'hF628;
  localparam logic [15:0] BAD  = 16'hF629;
  localparam logic [14:0] SEED = 15'h57E5;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, ib = 1'b0, iv = 1'b0;
  logic out_bit, out_valid, out_sof, out_eof, descr_load, descr_enable, locked;
  logic [14:0] descr_seed;
  logic [1:0]  state;
  logic [7:0]  sync_err_cnt;

  always #5 clk = ~clk;

  descrambler_sync_ctrl dut (
    .clk_i(clk), .rst_i(rst), .ctrl_en_i(en), .in_bit_i(ib), .in_valid_i(iv),
    .out_bit_o(out_bit), .out_valid_o(out_valid), .out_sof_o(out_sof),
    .out_eof_o(out_eof), .descr_load_o(descr_load), .descr_enable_o(descr_enable),
    .descr_seed_o(descr_seed), .locked_o(locked), .state_o(state),
    .sync_err_cnt_o(sync_err_cnt)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // reference model: mode 0 hunt, 1 verify, 2 locked; window from bit history
  int m_st = 0, m_pos = 0, m_hits = 0, m_miss = 0, m_err = 0;
  bit hist[$];
  bit e_val, e_bit, e_sof, e_eof, e_load;

  task automatic model(input bit b, input bit v, input bit e, input bit r);
    int w;
    bit hit, cp;
    {e_val, e_bit, e_sof, e_eof, e_load} = '0;
    if (r || !e) begin
      m_st = 0; m_pos = 0; m_hits = 0; m_miss = 0;
      hist.delete();
      if (r) m_err = 0;
      return;
    end
    if (!v) return;
    hist.push_back(b);
    if (hist.size() > SL) void'(hist.pop_front());
    w = 0;
    foreach (hist[i]) w = (w << 1) | int'(hist[i]);
    hit = (w == int'(SW));
    cp  = (m_pos == FL - 1);
    if (m_st == 0) begin
      if (hit) begin
        m_st = (LH == 1) ? 2 : 1; m_hits = 1; m_miss = 0; m_pos = 0; e_load = 1;
      end
      return;
    end
    if (m_st == 1 && cp) begin
      if (hit) begin
        m_hits++; e_load = 1;
        if (m_hits == LH) begin m_st = 2; m_miss = 0; end
      end else m_st = 0;
    end else if (m_st == 2) begin
      if (m_pos < PL) begin
        e_val = 1; e_bit = b; e_sof = (m_pos == 0); e_eof = (m_pos == PL - 1);
      end
      if (cp) begin
        if (hit) begin m_miss = 0; e_load = 1; end
        else begin
          m_miss++;
          if (m_err < 255) m_err++;
          if (m_miss == LM) m_st = 0; else e_load = 1;
        end
      end
    end
    m_pos = (m_pos + 1) % FL;
  endtask

  function automatic bit ks(input logic [14:0] s);
    return s[14] ^ s[13];
  endfunction
  function automatic logic [14:0] adv(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  int n_val, n_sof, n_eof, n_load;
  bit raw_q[$], dq[$];
  logic [14:0] rx = '0;

  task automatic clr_cnt();
    n_val = 0; n_sof = 0; n_eof = 0; n_load = 0;
    raw_q.delete(); dq.delete();
  endtask

  task automatic tick(input bit b, input bit v, input bit e = 1'b1, input bit r = 1'b0);
    ib = b; iv = v; en = e; rst = r;
    @(posedge clk);
    model(b, v, e, r);
    #1;
    chk("state", 64'(state), 64'(m_st));
    chk("lock", 64'(locked), 64'(m_st == 2));
    chk("pay", {out_valid, out_bit, out_sof, out_eof, descr_enable},
        {e_val, e_bit, e_sof, e_eof, e_val});
    chk("load", 64'(descr_load), 64'(e_load));
    chk("err", 64'(sync_err_cnt), 64'(m_err));
    chk("seed", 64'(descr_seed), 64'(SEED));
    n_val += int'(out_valid); n_sof += int'(out_sof);
    n_eof += int'(out_eof);   n_load += int'(descr_load);
    if (descr_load) rx = SEED;
    if (out_valid) raw_q.push_back(out_bit);
    if (descr_enable) begin
      dq.push_back(out_bit ^ ks(rx));
      rx = adv(rx);
    end
  endtask

  function automatic logic [63:0] rand_pay();
    logic [63:0] p;
    int run = 0;
    for (int i = 0; i < PL; i++) begin
      p[i] = 1'($urandom_range(1));
      if (run == 3) p[i] = 1'b0;  // no run of four ones, so no in-payload sync
      run = p[i] ? run + 1 : 0;
    end
    return p;
  endfunction

  function automatic logic [63:0] scr(input logic [63:0] p);
    logic [63:0] q;
    logic [14:0] s = SEED;
    for (int i = 0; i < PL; i++) begin
      q[i] = p[i] ^ ks(s);
      s = adv(s);
    end
    return q;
  endfunction

  function automatic logic [63:0] qvec(input bit q[$]);
    logic [63:0] v = '0;
    for (int i = 0; i < PL && i < q.size(); i++) v[i] = q[i];
    return v;
  endfunction

  task automatic send_sync(input logic [15:0] sy);
    for (int i = SL - 1; i >= 0; i--) tick(sy[i], 1'b1);
  endtask

  task automatic send_bits(input logic [63:0] p, input logic [15:0] sy, input int gap);
    for (int i = 0; i < PL; i++) begin
      while (int'($urandom_range(99)) < gap) tick(1'($urandom_range(1)), 1'b0);
      tick(p[i], 1'b1);
    end
    send_sync(sy);
  endtask

  logic [63:0] p;

  initial begin
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst.state", 64'(state), 0);
    chk("rst.out", {out_valid, out_bit, out_sof, out_eof, descr_load, descr_enable, locked}, 0);
    chk("rst.err", 64'(sync_err_cnt), 0);
    chk("rst.seed", 64'(descr_seed), 64'(SEED));

    // acquisition over three clean frames
    send_bits(rand_pay(), SW, 0); chk("A.verify", 64'(state), 1);
    send_bits(rand_pay(), SW, 0); chk("A.lock", 64'(state), 2);
    clr_cnt(); p = rand_pay(); send_bits(p, SW, 0);
    chk("A.nval", n_val, 64); chk("A.sof", n_sof, 1); chk("A.eof", n_eof, 1);
    chk("A.load", n_load, 1); chk("A.bits", qvec(raw_q), p);

    // flywheel: two misses then a hit, twice; then three misses drop lock
    repeat (2) send_bits(rand_pay(), BAD, 0);
    chk("B.hold", 64'(state), 2);
    send_bits(rand_pay(), SW, 0);
    chk("B.lock", 64'(state), 2); chk("B.err", 64'(sync_err_cnt), 2);
    repeat (2) send_bits(rand_pay(), BAD, 0);
    send_bits(rand_pay(), SW, 0);
    chk("B.clr", 64'(state), 2); chk("B.err2", 64'(sync_err_cnt), 4);
    repeat (2) send_bits(rand_pay(), BAD, 0);
    chk("B.hold2", 64'(state), 2);
    clr_cnt(); send_bits(rand_pay(), BAD, 0);
    chk("B.drop", 64'(state), 0); chk("B.err3", 64'(sync_err_cnt), 7);
    chk("B.noload", n_load, 0);
    clr_cnt(); send_bits(rand_pay(), BAD, 0);
    chk("B.noval", n_val, 0);

    // ctrl_en abort at payload bit 30 keeps the error count
    send_bits(rand_pay(), SW, 0); send_bits(rand_pay(), SW, 0);
    chk("D.lock", 64'(state), 2);
    p = rand_pay();
    for (int i = 0; i < 30; i++) tick(p[i], 1'b1);
    tick(p[30], 1'b1, 1'b0);
    chk("D.state", 64'(state), 0);
    chk("D.out", {out_valid, out_sof, out_eof, descr_load, descr_enable, locked}, 0);
    chk("D.err", 64'(sync_err_cnt), 7);
    clr_cnt();
    for (int i = 31; i < PL; i++) tick(p[i], 1'b1);
    send_sync(SW);
    chk("D.eof", n_eof, 0);

    // rst abort at payload bit 30 clears everything
    send_bits(rand_pay(), SW, 0); chk("E.lock", 64'(state), 2);
    p = rand_pay();
    for (int i = 0; i < 30; i++) tick(p[i], 1'b1);
    tick(p[30], 1'b1, 1'b1, 1'b1);
    chk("E.state", 64'(state), 0);
    chk("E.out", {out_valid, out_sof, out_eof, descr_load, descr_enable, locked}, 0);
    chk("E.err", 64'(sync_err_cnt), 0);
    clr_cnt();
    for (int i = 31; i < PL; i++) tick(p[i], 1'b1);
    send_sync(BAD);
    chk("E.eof", n_eof, 0);

    // random in_valid gaps during a locked frame
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(rand_pay(), SW, 0); send_bits(rand_pay(), SW, 0);
    clr_cnt(); p = rand_pay(); send_bits(p, SW, 50);
    chk("C.nval", n_val, 64); chk("C.bits", qvec(raw_q), p);
    chk("C.load", n_load, 1); chk("C.lock", 64'(state), 2);

    // sync pattern inside VERIFY payload, true sync corrupted
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(rand_pay(), SW, 0); chk("V.verify", 64'(state), 1);
    p = rand_pay();
    for (int j = 0; j < SL; j++) p[20 + j] = SW[SL - 1 - j];
    clr_cnt();
    for (int i = 0; i < PL; i++) tick(p[i], 1'b1);
    chk("V.ignore", 64'(state), 1); chk("V.noload", n_load, 0);
    send_sync(BAD);
    chk("V.hunt", 64'(state), 0);

    // closed loop: scrambled payload recovered through the descrambler
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(rand_pay(), SW, 0);
    send_bits(scr(rand_pay()), SW, 0);
    for (int f = 0; f < 100; f++) begin
      p = rand_pay();
      clr_cnt();
      send_bits(scr(p), SW, 0);
      chk("L.len", 64'(dq.size()), 64);
      chk("L.data", qvec(dq), p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
